// File: rtl/qea.sv
// qea: state-vector quantum circuit emulator. The host loads a gate program
// into the context RAM and an initial state into the state RAM, pulses
// i_start, waits for o_complete and reads the final state back.
//
// Host port protocol: there is no valid/ready handshake. A host state access
// (i_state_ena) is accepted only while the engine is IDLE or DONE, and read
// data appears on o_state_dout one cycle after the accepted access
// (read-first). Context writes are accepted in any state.
module qea #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int ALU_DATA_WIDTH          = DATA_WIDTH,
  parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_DATA_WIDTH         = 2*DATA_WIDTH,
  parameter int GATE_ADDR_WIDTH         = 6,
  parameter int GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  input  logic                               i_ctx_en,
  input  logic                               i_ctx_wea,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ctx_addr,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0] i_ctx_data,
  input  logic                               i_state_ena,
  input  logic                               i_state_wea,
  input  logic [STATE_ADDR_WIDTH-1:0]        i_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_state_dina,
  output logic                               o_complete,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_state_dout,
  output logic [2:0]                         o_fsm_state
);

  localparam int SW    = STATE_DATA_WIDTH;
  localparam int RW    = PE_NUM*SW;
  localparam int IDX_W = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int CAW   = GATE_CONTEXT_ADDR_WIDTH;
  localparam int AW    = ALU_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LOAD_U, S_APPLY_RD, S_APPLY_WR0, S_APPLY_WR1, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [RW-1:0]              state_mem [2**STATE_ADDR_WIDTH];
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_mem [2**CAW];
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_q;
  logic [CAW-1:0]             pc, ctx_raddr;
  logic [GATE_ADDR_WIDTH-1:0] ld_cnt;
  logic [GATE_DATA_WIDTH-1:0] u_buf [4];
  logic [IDX_W-1:0]           pair_cnt, pair_last, mask_lo, k0, k1;
  logic [5:0]                 t_q, c_q;
  logic                       ctrl_q;
  logic [RW-1:0]              rd0_q, rd1_q;

  // Complex multiply in Q format: full-width signed products, arithmetic
  // shift, low AW bits kept.
  function automatic logic [SW-1:0] cmul(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic signed [AW-1:0]   ar, ai, br, bi;
    logic signed [2*AW-1:0] pr, pi;
    ar = a[SW-1:AW]; ai = a[AW-1:0];
    br = b[SW-1:AW]; bi = b[AW-1:0];
    pr = ((2*AW)'(ar) * (2*AW)'(br) - (2*AW)'(ai) * (2*AW)'(bi)) >>> NUM_FRAC_BIT;
    pi = ((2*AW)'(ar) * (2*AW)'(bi) + (2*AW)'(ai) * (2*AW)'(br)) >>> NUM_FRAC_BIT;
    return {pr[AW-1:0], pi[AW-1:0]};
  endfunction

  function automatic logic [SW-1:0] cadd(input logic [SW-1:0] a, input logic [SW-1:0] b);
    return {a[SW-1:AW] + b[SW-1:AW], a[AW-1:0] + b[AW-1:0]};
  endfunction

  // Lane 0 sits in the most significant slice of a row.
  function automatic logic [SW-1:0] get_lane(input logic [RW-1:0] row, input logic [PE_NUM_WIDTH-1:0] lane);
    return row[(PE_NUM-1-int'(lane))*SW +: SW];
  endfunction

  function automatic logic [RW-1:0] set_lane(input logic [RW-1:0] row, input logic [PE_NUM_WIDTH-1:0] lane,
                                             input logic [SW-1:0] val);
    logic [RW-1:0] r;
    r = row;
    r[(PE_NUM-1-int'(lane))*SW +: SW] = val;
    return r;
  endfunction

  // Header decode: opcode [63:56], target [45:40], control [37:32].
  logic [7:0] hdr_op;
  logic [5:0] hdr_t, hdr_c;
  logic       hdr_gate, hdr_ctrl, hdr_skip;
  logic       unused_hdr;
  assign hdr_op     = ctx_q[63:56];
  assign hdr_t      = ctx_q[45:40];
  assign hdr_c      = ctx_q[37:32];
  assign unused_hdr = ^{ctx_q[55:46], ctx_q[39:38], ctx_q[31:0]};
  assign hdr_gate   = (hdr_op == 8'h01) || (hdr_op == 8'h02);
  assign hdr_ctrl   = (hdr_op == 8'h02) && (hdr_c != hdr_t);
  assign hdr_skip   = (hdr_t >= i_qbit_num) || (hdr_ctrl && (hdr_c >= i_qbit_num));

  // Pair enumeration: insert a zero at bit t of the pair counter to get k0.
  logic [STATE_ADDR_WIDTH-1:0] row0, row1;
  logic [PE_NUM_WIDTH-1:0]     lane0, lane1;
  logic                        same_row, last_pair, active, host_ok;
  logic [SW-1:0]               a0, a1, a0n, a1n;
  logic [RW-1:0]               row0_new, row0_merged, row1_new;

  assign pair_last   = (IDX_W'(1) << (i_qbit_num - 6'd1)) - IDX_W'(1);
  assign mask_lo     = (IDX_W'(1) << t_q) - IDX_W'(1);
  assign k0          = ((pair_cnt & ~mask_lo) << 1) | (pair_cnt & mask_lo);
  assign k1          = k0 | (IDX_W'(1) << t_q);
  assign row0        = k0[IDX_W-1:PE_NUM_WIDTH];
  assign row1        = k1[IDX_W-1:PE_NUM_WIDTH];
  assign lane0       = k0[PE_NUM_WIDTH-1:0];
  assign lane1       = k1[PE_NUM_WIDTH-1:0];
  assign same_row    = (row0 == row1);
  assign last_pair   = (pair_cnt == pair_last);
  assign active      = !ctrl_q || (((k0 >> c_q) & IDX_W'(1)) != '0);
  assign host_ok     = (state == S_IDLE) || (state == S_DONE);
  assign a0          = get_lane(rd0_q, lane0);
  assign a1          = get_lane(rd1_q, lane1);
  assign a0n         = cadd(cmul(u_buf[0], a0), cmul(u_buf[1], a1));
  assign a1n         = cadd(cmul(u_buf[2], a0), cmul(u_buf[3], a1));
  assign row0_new    = set_lane(rd0_q, lane0, a0n);
  assign row0_merged = same_row ? set_lane(row0_new, lane1, a1n) : row0_new;
  assign row1_new    = set_lane(rd1_q, lane1, a1n);
  assign o_complete  = (state == S_DONE);
  assign o_fsm_state = state;

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: fetch, decode, load 4 matrix words, sweep all pairs.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (i_start) state_nx = S_FETCH;
      S_FETCH:        state_nx = S_DECODE;
      S_DECODE: begin
        if (!hdr_gate)     state_nx = S_DONE;
        else if (hdr_skip) state_nx = S_FETCH;
        else               state_nx = S_LOAD_U;
      end
      S_LOAD_U:       if (ld_cnt == GATE_ADDR_WIDTH'(4)) state_nx = S_APPLY_RD;
      S_APPLY_RD:     state_nx = S_APPLY_WR0;
      S_APPLY_WR0: begin
        if (!same_row)      state_nx = S_APPLY_WR1;
        else if (last_pair) state_nx = S_FETCH;
        else                state_nx = S_APPLY_RD;
      end
      S_APPLY_WR1:    state_nx = last_pair ? S_FETCH : S_APPLY_RD;
      default:        state_nx = S_IDLE;
    endcase
  end

  // Program counter, gate registers and pair counter.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc       <= '0;
      ld_cnt   <= '0;
      pair_cnt <= '0;
      t_q      <= '0;
      c_q      <= '0;
      ctrl_q   <= 1'b0;
      for (int i = 0; i < 4; i++) u_buf[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (i_start) pc <= '0;
        S_DECODE: begin
          t_q      <= hdr_t;
          c_q      <= hdr_c;
          ctrl_q   <= hdr_ctrl;
          ld_cnt   <= '0;
          pair_cnt <= '0;
          if (hdr_gate && hdr_skip) pc <= pc + CAW'(5);
        end
        S_LOAD_U: begin
          ld_cnt <= ld_cnt + GATE_ADDR_WIDTH'(1);
          if (ld_cnt != '0) begin
            u_buf[0] <= u_buf[1];
            u_buf[1] <= u_buf[2];
            u_buf[2] <= u_buf[3];
            u_buf[3] <= ctx_q;
          end
          if (ld_cnt == GATE_ADDR_WIDTH'(4)) pc <= pc + CAW'(5);
        end
        S_APPLY_WR0: if (same_row) pair_cnt <= pair_cnt + IDX_W'(1);
        S_APPLY_WR1: pair_cnt <= pair_cnt + IDX_W'(1);
        default: ;
      endcase
    end
  end

  // Context read address: header at pc, matrix words at pc+1..pc+4.
  always_comb begin
    ctx_raddr = pc;
    if (state == S_LOAD_U) ctx_raddr = pc + CAW'(ld_cnt) + CAW'(1);
  end

  // Context RAM: host write port and one engine read port.
  always_ff @(posedge clk) begin
    if (i_ctx_en && i_ctx_wea) ctx_mem[i_ctx_addr] <= i_ctx_data;
    ctx_q <= ctx_mem[ctx_raddr];
  end

  // Single state-RAM write port shared by the host and the engine.
  logic                        mem_we;
  logic [STATE_ADDR_WIDTH-1:0] mem_waddr;
  logic [RW-1:0]               mem_wdata;
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (host_ok && i_state_ena && i_state_wea) begin
      mem_we = 1'b1; mem_waddr = i_state_addra; mem_wdata = i_state_dina;
    end else if (state == S_APPLY_WR0 && active) begin
      mem_we = 1'b1; mem_waddr = row0; mem_wdata = row0_merged;
    end else if (state == S_APPLY_WR1 && active) begin
      mem_we = 1'b1; mem_waddr = row1; mem_wdata = row1_new;
    end
  end

  // State RAM write and engine pair reads.
  always_ff @(posedge clk) begin
    if (mem_we) state_mem[mem_waddr] <= mem_wdata;
    rd0_q <= state_mem[row0];
    rd1_q <= state_mem[row1];
  end

  // Host read port, read-first, holds when not enabled.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                         o_state_dout <= '0;
    else if (host_ok && i_state_ena)   o_state_dout <= state_mem[i_state_addra];
  end

endmodule

// File: tb/tb_qea.sv
// tb_qea: randomized and directed checks of qea against a behavioural
// state-vector model.
module tb_qea;
  localparam int RW = 256;
  localparam logic [63:0] ONE  = 64'h40000000_00000000;
  localparam logic [63:0] HAD  = 64'h2D413CCD_00000000;
  localparam logic [63:0] NHAD = 64'hD2BEC333_00000000;
  localparam logic [63:0] IMAG = 64'h00000000_40000000;
  localparam logic [63:0] ENDW = 64'hFF000000_00000000;

  logic          clk, rst_n, i_start;
  logic [5:0]    i_qbit_num;
  logic          i_ctx_en, i_ctx_wea;
  logic [15:0]   i_ctx_addr;
  logic [63:0]   i_ctx_data;
  logic          i_state_ena, i_state_wea;
  logic [15:0]   i_state_addra;
  logic [RW-1:0] i_state_dina;
  logic          o_complete;
  logic [RW-1:0] o_state_dout;
  logic [2:0]    o_fsm_state;

  qea dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_qbit_num(i_qbit_num),
    .i_ctx_en(i_ctx_en), .i_ctx_wea(i_ctx_wea), .i_ctx_addr(i_ctx_addr), .i_ctx_data(i_ctx_data),
    .i_state_ena(i_state_ena), .i_state_wea(i_state_wea), .i_state_addra(i_state_addra),
    .i_state_dina(i_state_dina), .o_complete(o_complete), .o_state_dout(o_state_dout),
    .o_fsm_state(o_fsm_state)
  );

  int            errors = 0;
  int            checks = 0;
  logic [RW-1:0] exp_q[$];
  logic [63:0]   prog[$];
  logic [63:0]   mdl [1024];
  int            n_cur;

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Behavioural model: complex arithmetic straight from the number format.
  function automatic logic [63:0] cmul_m(input logic [63:0] a, input logic [63:0] b);
    longint ar, ai, br, bi, re, im;
    logic [63:0] r, i;
    ar = longint'($signed(a[63:32])); ai = longint'($signed(a[31:0]));
    br = longint'($signed(b[63:32])); bi = longint'($signed(b[31:0]));
    re = (ar*br - ai*bi) >>> 30;
    im = (ar*bi + ai*br) >>> 30;
    r = re; i = im;
    return {r[31:0], i[31:0]};
  endfunction

  function automatic logic [63:0] cadd_m(input logic [63:0] a, input logic [63:0] b);
    return {a[63:32] + b[63:32], a[31:0] + b[31:0]};
  endfunction

  task automatic model_gate(input int t, input int c, input bit ctrl,
                            input logic [63:0] u00, u01, u10, u11);
    int k1;
    logic [63:0] a0, a1;
    for (int k = 0; k < (1 << n_cur); k++) begin
      if (((k >> t) & 1) == 0 && (!ctrl || ((k >> c) & 1) == 1)) begin
        k1 = k | (1 << t);
        a0 = mdl[k]; a1 = mdl[k1];
        mdl[k]  = cadd_m(cmul_m(u00, a0), cmul_m(u01, a1));
        mdl[k1] = cadd_m(cmul_m(u10, a0), cmul_m(u11, a1));
      end
    end
  endtask

  task automatic model_prog();
    int pc, op, t, c;
    bit ctrl;
    logic [63:0] w;
    pc = 0;
    while (pc < prog.size()) begin
      w = prog[pc];
      op = int'(w[63:56]); t = int'(w[45:40]); c = int'(w[37:32]);
      if (op != 1 && op != 2) break;
      ctrl = (op == 2) && (c != t);
      if (t < n_cur && !(ctrl && c >= n_cur))
        model_gate(t, c, ctrl, prog[pc+1], prog[pc+2], prog[pc+3], prog[pc+4]);
      pc += 5;
    end
  endtask

  function automatic logic [RW-1:0] row_of(input int r);
    return {mdl[4*r], mdl[4*r+1], mdl[4*r+2], mdl[4*r+3]};
  endfunction

  task automatic add_gate(input logic [7:0] op, input int t, input int c,
                          input logic [63:0] u00, u01, u10, u11);
    prog.push_back({op, 10'b0, 6'(t), 2'b0, 6'(c), 32'b0});
    prog.push_back(u00); prog.push_back(u01); prog.push_back(u10); prog.push_back(u11);
  endtask

  task automatic clear_state();
    for (int k = 0; k < 1024; k++) mdl[k] = '0;
  endtask

  // Driver tasks: each starts and ends 1 time unit after a rising edge.
  task automatic ctx_wr(input int a, input logic [63:0] d);
    i_ctx_en = 1'b1; i_ctx_wea = 1'b1; i_ctx_addr = 16'(a); i_ctx_data = d;
    @(posedge clk); #1;
    i_ctx_en = 1'b0; i_ctx_wea = 1'b0;
  endtask

  task automatic state_wr(input int r, input logic [RW-1:0] d);
    i_state_ena = 1'b1; i_state_wea = 1'b1; i_state_addra = 16'(r); i_state_dina = d;
    @(posedge clk); #1;
    i_state_ena = 1'b0; i_state_wea = 1'b0;
  endtask

  task automatic state_rd(input int r, output logic [RW-1:0] d);
    i_state_ena = 1'b1; i_state_wea = 1'b0; i_state_addra = 16'(r);
    @(posedge clk); #1;
    i_state_ena = 1'b0;
    d = o_state_dout;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag, output int cyc);
    cyc = 0;
    while (!o_complete && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " complete"}, RW'(o_complete), RW'(1'b1));
  endtask

  task automatic load_all();
    i_qbit_num = 6'(n_cur);
    for (int i = 0; i < prog.size(); i++) ctx_wr(i, prog[i]);
    for (int r = 0; r < (1 << (n_cur - 2)); r++) state_wr(r, row_of(r));
  endtask

  task automatic compare_rows(input string tag);
    logic [RW-1:0] d, e;
    for (int r = 0; r < (1 << (n_cur - 2)); r++) exp_q.push_back(row_of(r));
    for (int r = 0; r < (1 << (n_cur - 2)); r++) begin
      state_rd(r, d);
      e = exp_q.pop_front();
      check($sformatf("%s row%0d", tag, r), d, e);
    end
  endtask

  function automatic int budget_of();
    return ((prog.size() - 1) / 5) * (8 + 4 * (1 << (n_cur - 1))) + 16;
  endfunction

  task automatic run_case(input string tag);
    int cyc, bud;
    load_all();
    bud = budget_of();
    model_prog();
    pulse_start();
    wait_done(bud, tag, cyc);
    compare_rows(tag);
  endtask

  // Main sequence.
  initial begin
    logic [RW-1:0] d;
    logic [RW-1:0] snap [8];
    logic [63:0]   m0, m1, m2;
    int            cyc;

    rst_n = 1'b1; i_start = 1'b0; i_qbit_num = 6'd7;
    i_ctx_en = 1'b0; i_ctx_wea = 1'b0; i_ctx_addr = '0; i_ctx_data = '0;
    i_state_ena = 1'b0; i_state_wea = 1'b0; i_state_addra = '0; i_state_dina = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    check("reset complete", RW'(o_complete), '0);
    check("reset dout", o_state_dout, '0);
    check("reset fsm", RW'(o_fsm_state), '0);

    // Load and read back with an END-only program.
    n_cur = 7; clear_state(); mdl[0] = ONE;
    prog.delete(); prog.push_back(ENDW);
    load_all();
    pulse_start();
    wait_done(10, "end only", cyc);
    check("end latency ok", RW'(cyc <= 10), RW'(1'b1));
    compare_rows("loadback");

    // Hadamard on qubit 0.
    clear_state(); mdl[0] = ONE;
    prog.delete(); add_gate(8'h01, 0, 0, HAD, HAD, HAD, NHAD); prog.push_back(ENDW);
    run_case("hadamard");
    state_rd(0, d);
    check("hadamard row0", d, {HAD, HAD, 64'h0, 64'h0});

    // X on qubit 3: pair spans rows 0 and 2.
    clear_state(); mdl[0] = ONE;
    prog.delete(); add_gate(8'h01, 3, 0, 64'h0, ONE, ONE, 64'h0); prog.push_back(ENDW);
    run_case("xgate");
    state_rd(2, d);
    check("xgate row2", d, {ONE, 64'h0, 64'h0, 64'h0});
    state_rd(0, d);
    check("xgate row0", d, '0);

    // Controlled phase c=0, t=1.
    clear_state();
    m0 = {$urandom, $urandom}; m1 = {$urandom, $urandom}; m2 = {$urandom, $urandom};
    mdl[0] = m0; mdl[1] = m1; mdl[2] = m2; mdl[3] = ONE;
    prog.delete(); add_gate(8'h02, 1, 0, ONE, 64'h0, 64'h0, IMAG); prog.push_back(ENDW);
    run_case("cphase");
    state_rd(0, d);
    check("cphase row0", d, {m0, m1, m2, IMAG});

    // Start while busy is ignored; a second run re-executes from address 0.
    n_cur = 6;
    for (int k = 0; k < 64; k++) mdl[k] = {$urandom, $urandom};
    prog.delete();
    add_gate(8'h01, 2, 0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    add_gate(8'h02, 4, 1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    prog.push_back(ENDW);
    load_all();
    model_prog();
    pulse_start();
    repeat (15) @(posedge clk);
    #1;
    pulse_start();
    wait_done(budget_of() + 20, "busy start", cyc);
    compare_rows("busy start");
    check("complete held", RW'(o_complete), RW'(1'b1));
    pulse_start();
    check("rerun clears complete", RW'(o_complete), '0);
    model_prog();
    wait_done(budget_of(), "rerun", cyc);
    compare_rows("rerun");

    // Random programs, including skipped gates, c==t and odd END opcodes.
    for (int it = 0; it < 6; it++) begin
      int ng;
      n_cur = $urandom_range(3, 8);
      prog.delete();
      ng = $urandom_range(1, 4);
      for (int g = 0; g < ng; g++)
        add_gate(8'($urandom_range(1, 2)), $urandom_range(0, n_cur), $urandom_range(0, n_cur - 1),
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      if (it % 2 == 0) prog.push_back(ENDW);
      else             prog.push_back({8'($urandom_range(3, 254)), 56'h0});
      for (int k = 0; k < (1 << n_cur); k++) mdl[k] = {$urandom, $urandom};
      run_case($sformatf("rand%0d", it));
    end

    // Reset asserted during APPLY.
    n_cur = 10; clear_state(); mdl[0] = ONE;
    prog.delete();
    add_gate(8'h01, 9, 0, HAD, HAD, HAD, NHAD);
    add_gate(8'h01, 0, 0, HAD, HAD, HAD, NHAD);
    prog.push_back(ENDW);
    load_all();
    state_rd(0, d);
    check("pre-reset readback", d, row_of(0));
    pulse_start();
    repeat (40) @(posedge clk);
    #1;
    check("in apply", RW'(o_fsm_state >= 3'd4 && o_fsm_state <= 3'd6), RW'(1'b1));
    #2 rst_n = 1'b1;
    #1;
    check("midrun rst complete", RW'(o_complete), '0);
    check("midrun rst dout", o_state_dout, '0);
    check("midrun rst fsm", RW'(o_fsm_state), '0);
    @(posedge clk); #1 rst_n = 1'b0;
    for (int r = 0; r < 8; r++) state_rd(r, snap[r]);
    repeat (50) @(posedge clk);
    #1;
    check("post-reset idle", RW'(o_complete), '0);
    for (int r = 0; r < 8; r++) begin
      state_rd(r, d);
      check($sformatf("post-reset row%0d stable", r), d, snap[r]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
